// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO write/read controllers.
// Pointer width rule: PTR_W = ADDR_WIDTH + 1 (the extra MSB separates full from empty).
package async_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int AF_GAP_DEF     = 2;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // Width-parameterized Gray conversions, called as gray_fn #(.W(n))::bin2gray(x).
  virtual class gray_fn #(parameter int W = 5);
    static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
    endfunction

    static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) begin
        b[i] = b[i+1] ^ g[i];
      end
      return b;
    endfunction
  endclass

endpackage

// File: rtl/async_fifo_wr_ctrl_gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary XOR prefix, shared by the write and read controllers.
module gray_to_bin
  import async_fifo_pkg::*;
#(
  parameter int PTR_W = 5
) (
  input  logic [PTR_W-1:0] gray,
  output logic [PTR_W-1:0] bin
);

  always_comb begin
    bin            = '0;
    bin[PTR_W-1]   = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write pointer, Gray pointer export, full/almost_full and fill level.
// Define ASYNC_FIFO_OVERFLOW_CHK_EN to add the sticky overflow output.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  output logic                  wr_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count
`ifdef ASYNC_FIFO_OVERFLOW_CHK_EN
  ,
  output logic                  overflow
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_GAP);

  logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic [PTR_W-1:0] wr_count_q, wr_count_d;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_full_pat;
  logic [PTR_W-1:0] fill_next;
  logic             acc;

  gray_to_bin #(.PTR_W(PTR_W)) u_rd_g2b (
    .gray (rd_ptr_gray_sync),
    .bin  (rd_bin)
  );

  // Write pointer a full lap ahead of the read pointer: top two Gray bits inverted.
  assign rd_full_pat = {~rd_ptr_gray_sync[ADDR_WIDTH -: 2], rd_ptr_gray_sync[ADDR_WIDTH-2:0]};

  always_comb begin
    acc           = wr_en & ~full_q;
    wr_bin_d      = wr_bin_q + PTR_W'(acc);
    wr_gray_d     = gray_fn #(.W(PTR_W))::bin2gray(wr_bin_d);
    fill_next     = wr_bin_d - rd_bin;
    full_d        = (wr_gray_d == rd_full_pat);
    almost_full_d = (fill_next >= AF_THRESH);
    wr_count_d    = fill_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign wr_ready    = ~full_q;
  assign ram_we      = wr_en & ~full_q;
  assign ram_waddr   = wr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = wr_count_q;

`ifdef ASYNC_FIFO_OVERFLOW_CHK_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl (ADDR_WIDTH=3, AF_GAP=2) against an occupancy-count model.
module tb_async_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int AFG   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [PW-1:0] rd_g = '0;
  logic          wr_ready, ram_we, full, almost_full;
  logic [AW-1:0] ram_waddr;
  logic [PW-1:0] wr_ptr_gray, wr_count;
`ifdef ASYNC_FIFO_OVERFLOW_CHK_EN
  logic          overflow;
`endif

  async_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_GAP(AFG)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .wr_ready         (wr_ready),
    .ram_we           (ram_we),
    .ram_waddr        (ram_waddr),
    .wr_ptr_gray      (wr_ptr_gray),
    .rd_ptr_gray_sync (rd_g),
    .full             (full),
    .almost_full      (almost_full),
    .wr_count         (wr_count)
`ifdef ASYNC_FIFO_OVERFLOW_CHK_EN
    ,
    .overflow         (overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: total accepted writes and total reads seen, as plain integers.
  int m_wr = 0;
  int m_rd = 0;
  int m_count = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit cmp_en = 0;

  function automatic logic [PW-1:0] g_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wr = 0; m_count = 0; m_full = 0; m_af = 0;
    end else begin
      if (wr_en && !m_full) m_wr = m_wr + 1;
      m_count = m_wr - m_rd;
      m_full  = (m_count == DEPTH);
      m_af    = (m_count >= DEPTH - AFG);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc_wr_count", 32'(wr_count), 32'(m_count));
      chk("cyc_full", 32'(full), 32'(m_full));
      chk("cyc_almost_full", 32'(almost_full), 32'(m_af));
      chk("cyc_wr_ptr_gray", 32'(wr_ptr_gray), 32'(g_of(m_wr)));
      chk("cyc_ram_waddr", 32'(ram_waddr), 32'(m_wr % DEPTH));
      chk("cyc_ram_we", 32'(ram_we), 32'(wr_en && !m_full));
      chk("cyc_wr_ready", 32'(wr_ready), 32'(!m_full));
    end
  end

  task automatic drive(input logic we, input int rd);
    wr_en = we;
    m_rd  = rd;
    rd_g  = g_of(rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [PW-1:0] gseq [8];
  logic [PW-1:0] prev_g;

  initial begin
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    #23 rst = 1'b0;
    #1;
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_wr_ptr_gray", 32'(wr_ptr_gray), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    cmp_en = 1;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 0);
      #1;
      chk("fill_ram_waddr", 32'(ram_waddr), 32'(i));
      chk("fill_ram_we", 32'(ram_we), 1);
      tick();
      chk("fill_gray", 32'(wr_ptr_gray), 32'(gseq[i]));
      if (i == 4) chk("fill_af_before", 32'(almost_full), 0);
      if (i == 5) begin
        chk("fill_af_at6", 32'(almost_full), 1);
        chk("fill_count6", 32'(wr_count), 6);
      end
    end
    chk("full_after8", 32'(full), 1);
    chk("count_after8", 32'(wr_count), 8);

    drive(1'b1, 0);
    #1;
    chk("wfull_ram_we", 32'(ram_we), 0);
    tick();
    chk("wfull_gray", 32'(wr_ptr_gray), 32'(4'b1100));
    drive(1'b0, 0);
    tick();
    chk("wfull_gray_hold", 32'(wr_ptr_gray), 32'(4'b1100));
`ifdef ASYNC_FIFO_OVERFLOW_CHK_EN
    chk("overflow_set", 32'(overflow), 1);
    tick();
    chk("overflow_sticky", 32'(overflow), 1);
`endif

    drive(1'b0, 1);
    tick();
    chk("drain1_full", 32'(full), 0);
    chk("drain1_count", 32'(wr_count), 7);
    chk("drain1_af", 32'(almost_full), 1);
    drive(1'b0, 2);
    tick();
    chk("drain2_count", 32'(wr_count), 6);
    chk("drain2_af", 32'(almost_full), 1);
    drive(1'b0, 3);
    tick();
    chk("drain3_count", 32'(wr_count), 5);
    chk("drain3_af", 32'(almost_full), 0);

    drive(1'b0, 4); tick();
    drive(1'b0, 5); tick();
    chk("wrap_start_count", 32'(wr_count), 3);
    for (int i = 0; i < 20; i++) begin
      prev_g = wr_ptr_gray;
      drive(1'b1, m_rd + 1);
      tick();
      chk("wrap_count", 32'(wr_count), 3);
      chk("wrap_full", 32'(full), 0);
      chk("wrap_gray_toggles", 32'($countones(prev_g ^ wr_ptr_gray)), 1);
    end

    for (int i = 0; i < 400; i++) begin
      int p;
      int rd;
      p  = (i < 200) ? 75 : 35;
      rd = m_rd;
      if (m_rd < m_wr && $urandom_range(0, 99) < 100 - p) rd = m_rd + 1;
      drive(($urandom_range(0, 99) < p) ? 1'b1 : 1'b0, rd);
      tick();
    end

    drive(1'b0, m_wr); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, m_rd);
      tick();
    end
    drive(1'b0, m_rd);
    chk("prereset_count", 32'(wr_count), 5);

    #2;
    cmp_en = 0;
    rst = 1'b1;
    #1;
    chk("arst_wr_count", 32'(wr_count), 0);
    chk("arst_gray", 32'(wr_ptr_gray), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_af", 32'(almost_full), 0);
    chk("arst_ram_waddr", 32'(ram_waddr), 0);
    #2;
    drive(1'b0, 0);
    rst = 1'b0;
    drive(1'b1, 0);
    #1;
    chk("post_rst_waddr", 32'(ram_waddr), 0);
    chk("post_rst_ram_we", 32'(ram_we), 1);
    cmp_en = 1;
    tick();
    chk("post_rst_gray", 32'(wr_ptr_gray), 32'(4'b0001));
    for (int i = 0; i < 30; i++) begin
      drive($urandom_range(0, 1) == 1, (m_rd < m_wr) ? m_rd + 32'($urandom_range(0, 1)) : m_rd);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
